// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: a 3-entry shadow scoreboard (EX/MEM/WB) drives
// load-use or no-forwarding stalls, registered forward selects, and HALT drain sequencing.
module hazard_stall_ctrl #(
    parameter int FORWARDING = 1,
    parameter int REG_W      = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_use_rs,
    input  logic             i_id_use_rt,
    input  logic             i_id_reg_write,
    input  logic             i_id_is_load,
    input  logic             i_id_halt,
    input  logic [REG_W-1:0] i_id_rd,
    input  logic             i_ex_branch_taken,
    output logic             o_stall,
    output logic             o_flush,
    output logic             o_fetch_en,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic [31:0]      o_stall_count,
    output logic [31:0]      o_hazard_count,
    output logic             o_halt_done
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             is_load;
        logic             halt;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    state_t    r_state;
    state_t    w_state_nxt;
    sb_entry_t r_ex;
    sb_entry_t r_mem;
    sb_entry_t r_wb;
    sb_entry_t w_ex_nxt;
    logic [1:0]  r_fwd_a;
    logic [1:0]  r_fwd_b;
    logic [1:0]  w_fwd_a_nxt;
    logic [1:0]  w_fwd_b_nxt;
    logic [31:0] r_stall_count;
    logic [31:0] r_hazard_count;
    logic        r_stall_prev;
    logic        w_stall;
    logic        w_admit;
    logic        w_fetch_en;
    logic        w_hazard;
    logic        w_rs_ex;
    logic        w_rt_ex;
    logic        w_rs_mem;
    logic        w_rt_mem;
    logic        w_unused_sb;

    assign w_rs_ex  = i_id_use_rs && r_ex.valid  && (i_id_rs == r_ex.rd);
    assign w_rt_ex  = i_id_use_rt && r_ex.valid  && (i_id_rt == r_ex.rd);
    assign w_rs_mem = i_id_use_rs && r_mem.valid && (i_id_rs == r_mem.rd);
    assign w_rt_mem = i_id_use_rt && r_mem.valid && (i_id_rt == r_mem.rd);

    // WB producers write the regfile before ID reads it, so they never stall.
    assign w_hazard = (FORWARDING != 0) ? ((w_rs_ex || w_rt_ex) && r_ex.is_load)
                                        : (w_rs_ex || w_rt_ex || w_rs_mem || w_rt_mem);

    // Only the WB halt tag is consumed; the rest of the entry is kept for visibility.
    assign w_unused_sb = ^{r_wb.valid, r_wb.rd, r_wb.is_load, r_ex.is_load};

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_admit     = 1'b0;
        w_fetch_en  = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_stall    = i_id_valid && w_hazard && !i_ex_branch_taken;
                w_admit    = i_id_valid && !w_stall && !i_ex_branch_taken;
                w_fetch_en = !w_stall;
                if (w_admit && i_id_halt) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_wb.halt) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Selects are evaluated one stage early: an EX producer will sit in MEM next cycle.
    always_comb begin
        w_ex_nxt.valid   = w_admit && i_id_reg_write && (i_id_rd != '0);
        w_ex_nxt.rd      = i_id_rd;
        w_ex_nxt.is_load = w_admit && i_id_is_load;
        w_ex_nxt.halt    = w_admit && i_id_halt;
        w_fwd_a_nxt      = FWD_RF;
        w_fwd_b_nxt      = FWD_RF;
        if ((FORWARDING != 0) && w_admit) begin
            if (w_rs_ex) begin
                w_fwd_a_nxt = FWD_MEM;
            end else if (w_rs_mem) begin
                w_fwd_a_nxt = FWD_WB;
            end
            if (w_rt_ex) begin
                w_fwd_b_nxt = FWD_MEM;
            end else if (w_rt_mem) begin
                w_fwd_b_nxt = FWD_WB;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= ST_RUN;
            r_ex           <= '0;
            r_mem          <= '0;
            r_wb           <= '0;
            r_fwd_a        <= FWD_RF;
            r_fwd_b        <= FWD_RF;
            r_stall_count  <= '0;
            r_hazard_count <= '0;
            r_stall_prev   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ex         <= w_ex_nxt;
            r_mem        <= r_ex;
            r_wb         <= r_mem;
            r_fwd_a      <= w_fwd_a_nxt;
            r_fwd_b      <= w_fwd_b_nxt;
            r_stall_prev <= w_stall;
            if (r_state != ST_HALTED) begin
                if (w_stall && (r_stall_count != '1)) begin
                    r_stall_count <= r_stall_count + 32'd1;
                end
                if (w_stall && !r_stall_prev && (r_hazard_count != '1)) begin
                    r_hazard_count <= r_hazard_count + 32'd1;
                end
            end
        end
    end

    assign o_stall        = w_stall;
    assign o_flush        = i_ex_branch_taken;
    assign o_fetch_en     = w_fetch_en;
    assign o_fwd_a        = r_fwd_a;
    assign o_fwd_b        = r_fwd_b;
    assign o_stall_count  = r_stall_count;
    assign o_hazard_count = r_hazard_count;
    assign o_halt_done    = (r_state == ST_HALTED);

endmodule
